// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer: two requesters share one 4-bit ALU, one op per 3 cycles.
// Latency: accept at t, ALU operands valid t+1, result and done at t+2. Ready only in IDLE, for the winner only.
module alu_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             req0_valid,
    input  logic [3:0]       req0_a,
    input  logic [3:0]       req0_b,
    input  logic [1:0]       req0_func,
    output logic             req0_ready,
    output logic             req0_done,
    output logic [7:0]       req0_result,
    input  logic             req1_valid,
    input  logic [3:0]       req1_a,
    input  logic [3:0]       req1_b,
    input  logic [1:0]       req1_func,
    output logic             req1_ready,
    output logic             req1_done,
    output logic [7:0]       req1_result,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [1:0]       alu_func,
    input  logic [7:0]       alu_out,
    output logic             busy,
    output logic             grant_id,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t state, state_nxt;
    logic   last_grant;
    logic   win;
    logic   accept;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // On a tie the requester that did not own the previous operation wins.
    always_comb begin
        state_nxt = state;
        win       = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    win = ~last_grant;
                end else begin
                    win = ~req0_valid;
                end
                accept = req0_valid | req1_valid;
                if (accept) begin
                    state_nxt = EXEC;
                end
            end
            EXEC:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = accept & ~win;
        req1_ready = accept & win;
        req0_done  = (state == DONE) & ~grant_id;
        req1_done  = (state == DONE) & grant_id;
        busy       = (state != IDLE);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            alu_a       <= 4'd0;
            alu_b       <= 4'd0;
            alu_func    <= 2'd0;
            grant_id    <= 1'b0;
            last_grant  <= 1'b1;
            req0_result <= 8'd0;
            req1_result <= 8'd0;
            op_count    <= '0;
        end else begin
            if (accept) begin
                alu_a      <= win ? req1_a    : req0_a;
                alu_b      <= win ? req1_b    : req0_b;
                alu_func   <= win ? req1_func : req0_func;
                grant_id   <= win;
                last_grant <= win;
            end
            if (state == EXEC) begin
                if (grant_id) begin
                    req1_result <= alu_out;
                end else begin
                    req0_result <= alu_out;
                end
            end
            if (state == DONE) begin
                op_count <= op_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a behavioural ALU model feeds alu_out; a second
// instance with a 2-bit counter shares the same stimulus to exercise counter wrap.
module tb_alu_arbiter;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic       req0_valid, req1_valid;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0] req0_func, req1_func;
    logic       req0_ready, req0_done, req1_ready, req1_done;
    logic [7:0] req0_result, req1_result;
    logic [3:0] alu_a, alu_b;
    logic [1:0] alu_func;
    logic [7:0] alu_out;
    logic       busy, grant_id;
    logic [7:0] op_count;

    logic       d2_req0_ready, d2_req0_done, d2_req1_ready, d2_req1_done;
    logic [7:0] d2_req0_result, d2_req1_result;
    logic [3:0] d2_alu_a, d2_alu_b;
    logic [1:0] d2_alu_func;
    logic [7:0] d2_alu_out;
    logic       d2_busy, d2_grant_id;
    logic [1:0] d2_op_count;

    int checks   = 0;
    int failures = 0;

    always #5 Clock = ~Clock;

    function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] f);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b};
        case (f)
            2'b00:   alu_f = {3'b000, s};
            2'b01:   alu_f = {7'd0, |{a, b}};
            2'b10:   alu_f = {7'd0, &{a, b}};
            default: alu_f = {a, b};
        endcase
    endfunction

    assign alu_out    = alu_f(alu_a, alu_b, alu_func);
    assign d2_alu_out = alu_f(d2_alu_a, d2_alu_b, d2_alu_func);

    alu_arbiter #(.CNT_W(8)) dut (
        .Clock(Clock), .Resetn(Resetn),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_func(req0_func),
        .req0_ready(req0_ready), .req0_done(req0_done), .req0_result(req0_result),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_func(req1_func),
        .req1_ready(req1_ready), .req1_done(req1_done), .req1_result(req1_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_out(alu_out),
        .busy(busy), .grant_id(grant_id), .op_count(op_count)
    );

    alu_arbiter #(.CNT_W(2)) dut2 (
        .Clock(Clock), .Resetn(Resetn),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_func(req0_func),
        .req0_ready(d2_req0_ready), .req0_done(d2_req0_done), .req0_result(d2_req0_result),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_func(req1_func),
        .req1_ready(d2_req1_ready), .req1_done(d2_req1_done), .req1_result(d2_req1_result),
        .alu_a(d2_alu_a), .alu_b(d2_alu_b), .alu_func(d2_alu_func), .alu_out(d2_alu_out),
        .busy(d2_busy), .grant_id(d2_grant_id), .op_count(d2_op_count)
    );

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic apply_reset;
        Resetn = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 4'd0; req0_b = 4'd0; req0_func = 2'd0;
        req1_a = 4'd0; req1_b = 4'd0; req1_func = 2'd0;
        tick();
        tick();
        Resetn = 1'b1;
        tick();
    endtask

    function automatic logic all_zero();
        all_zero = (alu_a == 4'd0) && (alu_b == 4'd0) && (alu_func == 2'd0) &&
                   (req0_result == 8'd0) && (req1_result == 8'd0) &&
                   !req0_done && !req1_done && !req0_ready && !req1_ready &&
                   !busy && !grant_id && (op_count == 8'd0);
    endfunction

    task automatic test_reset;
        Resetn = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        checks++;
        if (all_zero() !== 1'b1) begin
            failures++;
            $display("FAIL reset_outputs got busy=%0b op_count=%0d result0=%h result1=%h want all zero",
                     busy, op_count, req0_result, req1_result);
        end
        Resetn = 1'b1;
        tick();
    endtask

    task automatic test_single_req0;
        apply_reset();
        req0_valid = 1'b1; req0_a = 4'h9; req0_b = 4'h8; req0_func = 2'b00;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            failures++;
            $display("FAIL single_ready got %b want 01", {req1_ready, req0_ready});
        end
        tick();
        req0_valid = 1'b0;
        #1;
        checks++;
        if ({alu_a, alu_b, busy, req0_done} !== {4'h9, 4'h8, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL single_exec got a=%h b=%h busy=%b done=%b want a=9 b=8 busy=1 done=0",
                     alu_a, alu_b, busy, req0_done);
        end
        tick();
        checks++;
        if ({req0_done, req0_result, req1_result} !== {1'b1, 8'h11, 8'h00}) begin
            failures++;
            $display("FAIL single_done got done=%b r0=%h r1=%h want done=1 r0=11 r1=00",
                     req0_done, req0_result, req1_result);
        end
        tick();
        checks++;
        if ({req0_done, busy, op_count} !== {1'b0, 1'b0, 8'd1}) begin
            failures++;
            $display("FAIL single_after got done=%b busy=%b cnt=%0d want done=0 busy=0 cnt=1",
                     req0_done, busy, op_count);
        end
    endtask

    task automatic test_contention;
        apply_reset();
        req0_valid = 1'b1; req0_a = 4'h3; req0_b = 4'hC; req0_func = 2'b11;
        req1_valid = 1'b1; req1_a = 4'h0; req1_b = 4'h0; req1_func = 2'b01;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            failures++;
            $display("FAIL tie_first_ready got %b want 01", {req1_ready, req0_ready});
        end
        tick();
        req0_valid = 1'b0;
        #1;
        checks++;
        if ({grant_id, req1_ready} !== 2'b00) begin
            failures++;
            $display("FAIL tie_exec got grant=%b ready1=%b want 0 0", grant_id, req1_ready);
        end
        tick();
        checks++;
        if ({req0_done, req0_result, req1_ready} !== {1'b1, 8'h3C, 1'b0}) begin
            failures++;
            $display("FAIL tie_done0 got done=%b r0=%h ready1=%b want 1 3c 0",
                     req0_done, req0_result, req1_ready);
        end
        tick();
        checks++;
        if (req1_ready !== 1'b1) begin
            failures++;
            $display("FAIL tie_second_ready got %b want 1", req1_ready);
        end
        tick();
        req1_valid = 1'b0;
        #1;
        checks++;
        if (grant_id !== 1'b1) begin
            failures++;
            $display("FAIL tie_grant1 got %b want 1", grant_id);
        end
        tick();
        checks++;
        if ({req1_done, req1_result} !== {1'b1, 8'h00}) begin
            failures++;
            $display("FAIL tie_done1 got done=%b r1=%h want 1 00", req1_done, req1_result);
        end
        tick();
        checks++;
        if ({busy, op_count} !== {1'b0, 8'd2}) begin
            failures++;
            $display("FAIL tie_end got busy=%b cnt=%0d want 0 2", busy, op_count);
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0] exp_rdy, exp_done;
        apply_reset();
        req0_valid = 1'b1; req0_a = 4'h1; req0_b = 4'h2; req0_func = 2'b00;
        req1_valid = 1'b1; req1_a = 4'h5; req1_b = 4'hA; req1_func = 2'b11;
        #1;
        for (int k = 0; k < 12; k++) begin
            exp_rdy  = ((k % 3) == 0) ? (((k / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            exp_done = ((k % 3) == 2) ? (((k / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            checks++;
            if ({req1_ready, req0_ready, req1_done, req0_done} !== {exp_rdy, exp_done}) begin
                failures++;
                $display("FAIL b2b_cycle%0d got rdy=%b done=%b want rdy=%b done=%b", k,
                         {req1_ready, req0_ready}, {req1_done, req0_done}, exp_rdy, exp_done);
            end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        checks++;
        if ({op_count, req0_result, req1_result} !== {8'd4, 8'h03, 8'h5A}) begin
            failures++;
            $display("FAIL b2b_totals got cnt=%0d r0=%h r1=%h want 4 03 5a",
                     op_count, req0_result, req1_result);
        end
    endtask

    task automatic test_and_reduce;
        logic [3:0] bvals [2] = '{4'hF, 4'hE};
        logic [7:0] exps  [2] = '{8'h01, 8'h00};
        for (int i = 0; i < 2; i++) begin
            req1_valid = 1'b1; req1_a = 4'hF; req1_b = bvals[i]; req1_func = 2'b10;
            #1;
            checks++;
            if (req1_ready !== 1'b1) begin
                failures++;
                $display("FAIL and_ready%0d got %b want 1", i, req1_ready);
            end
            tick();
            req1_valid = 1'b0;
            tick();
            checks++;
            if ({req1_done, req1_result, req0_result} !== {1'b1, exps[i], 8'h03}) begin
                failures++;
                $display("FAIL and_result%0d got done=%b r1=%h r0=%h want 1 %h 03",
                         i, req1_done, req1_result, req0_result, exps[i]);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_exec;
        req0_valid = 1'b1; req0_a = 4'h7; req0_b = 4'h7; req0_func = 2'b11;
        tick();
        req0_valid = 1'b0;
        #1;
        Resetn = 1'b0;
        #1;
        checks++;
        if (all_zero() !== 1'b1) begin
            failures++;
            $display("FAIL midexec_reset got busy=%b cnt=%0d r0=%h r1=%h a=%h want all zero",
                     busy, op_count, req0_result, req1_result, alu_a);
        end
        tick();
        checks++;
        if ({req0_done, req1_done, req0_result} !== {1'b0, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL midexec_nodone got done=%b%b r0=%h want 00 00",
                     req1_done, req0_done, req0_result);
        end
        Resetn = 1'b1;
        tick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            failures++;
            $display("FAIL midexec_tie got %b want 01", {req1_ready, req0_ready});
        end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_count_wrap;
        logic [1:0] exp2;
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            req0_valid = 1'b1; req0_a = 4'(k); req0_b = 4'h1; req0_func = 2'b00;
            tick();
            req0_valid = 1'b0;
            tick();
            tick();
            exp2 = 2'((k + 1) % 4);
            checks++;
            if ({d2_op_count, op_count} !== {exp2, 8'(k + 1)}) begin
                failures++;
                $display("FAIL wrap_op%0d got cnt2=%0d cnt8=%0d want %0d %0d",
                         k, d2_op_count, op_count, exp2, k + 1);
            end
        end
    endtask

    initial begin
        Resetn = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 4'd0; req0_b = 4'd0; req0_func = 2'd0;
        req1_a = 4'd0; req1_b = 4'd0; req1_func = 2'd0;
        test_reset();
        test_single_req0();
        test_contention();
        test_back_to_back();
        test_and_reduce();
        test_reset_mid_exec();
        test_count_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
